// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch for the multicycle datapath.
// Runs the shared 10-phase counter, a req/ack instruction read, and halts on HALT_WORD.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [3:0]  phase,
  output logic        halted
);

  // State is carried entirely by {halted, imem_req}; req is only ever high in phase 1.
  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  logic        r_req;
  logic        r_halted;
  logic        r_valid;
  logic [3:0]  r_phase;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_instr;
  logic [1:0]  w_state;
  logic [3:0]  w_phase_next;

  assign w_state      = {r_halted, r_req};
  assign w_phase_next = (r_phase == 4'd9) ? 4'd0 : r_phase + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_halted   <= 1'b0;
      r_valid    <= 1'b0;
      r_phase    <= 4'd0;
      r_pc       <= RESET_PC;
      r_pc_plus4 <= RESET_PC + 32'd4;
      r_instr    <= 32'd0;
    end else begin
      case (w_state)
        ST_HALT: begin
        end
        ST_WAIT: begin
          // Holding in phase 1 until the memory acknowledges; no timeout.
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_phase <= 4'd2;
            if (imem_rdata == HALT_WORD)
              r_halted <= 1'b1;
          end
        end
        default: begin
          r_phase <= w_phase_next;
          case (r_phase)
            4'd0:    r_req      <= 1'b1;
            4'd2:    r_pc_plus4 <= r_pc + 32'd4;
            4'd5:    r_pc       <= next_pc;
            4'd9:    r_valid    <= 1'b0;
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc_plus4;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign phase       = r_phase;
  assign halted      = r_halted;

endmodule
